pid_seq_ctrl: RTL and testbench
===============================

// Module: pid_seq_ctrl
// PURPOSE
//  Sample scheduler and step sequencer for the PID control loop. It triggers samples from a prescaler
//  or an external strobe, then computes P, I and D in turn on one shared multiplier. It holds
//  run-time-writable gains and drives the clamped 8-bit actuator output. Sits between tt_um top I/O and the plant.
// PARAMETERS
//  DW     8   setpoint/feedback/output width (unsigned)
//  GW     8   gain width (unsigned Kp/Ki/Kd)
//  ACCW   16  integrator width (signed, saturating)
//  DIVW   16  prescaler width
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     async active-low reset
//  cfg_we         in   1     config write strobe, one cycle per write
//  cfg_addr       in   2     0=Kp 1=Ki 2=Kd 3=CTRL
//  cfg_wdata      in   8     write data; CTRL: bit0 enable, bit1 clr_integ (self-clearing), bit2 clr_ovr
//  rate_div       in   DIVW  sample period-1 in clk cycles; 0 = sample on sample_req only
//  sample_req     in   1     external sample strobe, used when rate_div==0
//  setpoint       in   DW    target
//  feedback       in   DW    measured value
//  control_signal out  DW    clamped PID output
//  busy           out  1     high while state != IDLE
//  done           out  1     one-cycle pulse when control_signal updates
//  sat_out        out  1     one-cycle pulse with done when the output was clamped
//  overrun        out  1     sticky: trigger arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0; gains, shadows, integral, prev_err, prescaler 0; CTRL=0; state IDLE.
//  Trigger: only when enable=1. rate_div!=0: prescaler counts 0..rate_div, then tick and wrap to 0.
//   Prescaler is held at 0 while disabled. rate_div==0: trigger = sample_req.
//  Trigger while busy: ignored, overrun<=1. Overrun clears only on a CTRL write with bit2=1.
//  Config: writes land in shadow registers at any time. Shadows copy into active gains in CAP,
//   so gains stay frozen mid-sample. A write and CAP in the same cycle: the new value is used.
//  clr_integ: sets a pending flag. At the next I step the integral restarts from 0, then the flag clears.
//  FSM: IDLE -> CAP -> P -> I -> D -> OUT -> IDLE, one cycle each, no stalls.
//   CAP: latch sp/fb; err = {0,sp} - {0,fb}, signed DW+1.
//   P:   acc = Kp*err.
//   I:   integ = sat_ACCW(integ + Ki*err); acc += integ.
//   D:   acc += Kd*(err - prev_err); prev_err <= err.
//   OUT: clamp acc to [0, 2^DW-1] into control_signal; done<=1; sat_out<=clamped.
//  Latency: trigger sampled at edge k; control_signal, done and sat_out are valid after edge k+5.
//   Next trigger is accepted at edge k+5 or later.
//  Widths: acc is signed, wide enough that no intermediate wraps (>= ACCW+GW+DW+3).
//   Only the integrator saturates, at +2^(ACCW-1)-1 / -2^(ACCW-1).
//  Async reset mid-sample: aborts immediately; state returns to IDLE with all values at reset.
//  control_signal holds its value between samples.
// CONFIGURATION
//  PID_ANTIWINDUP_EN defined: conditional integration. The I step skips the integrator update when
//   the previous sample clamped high and err>0, or clamped low and err<0. acc still adds the held integral.
//  Not defined: the integrator updates every sample, limited only by ACCW saturation.
// TESTING
//  1 Kp=2 Ki=0 Kd=0, enable, rate_div=0, sp=100 fb=60, pulse sample_req -> 5 cycles later ctrl=80,
//    done=1 for 1 cycle, sat_out=0.
//  2 Kp=2: sp=10 fb=50 -> ctrl=0, sat_out=1; sp=255 fb=0 -> ctrl=255, sat_out=1.
//  3 Kp=0 Ki=1: err=10 for 3 samples -> 10,20,30; write CTRL=0x03; next sample -> 10.
//  4 Kp=0 Kd=1 after reset: err=20 then err=30 -> 20 then 10. err=30 then 20 -> 0 (clamped).
//  5 rate_div=9, enable -> done every 10 cycles. Extra sample_req with rate_div=0 while busy ->
//    overrun=1 until CTRL bit2 write. Write Kp mid-sample -> used from next sample only.
//  6 rst_n low during state P -> all outputs 0 asynchronously; the next sample after release gives
//    the correct value from zero history.
//  7 (EN) Ki=255, err=+200 repeated until clamped high -> integral stops growing. Without EN it
//    climbs to 32767.

Source files
------------

// File: rtl/pid_seq_ctrl.sv
// Sample scheduler and P/I/D step sequencer sharing one multiplier, with shadowed gains and clamped output.
// Define PID_ANTIWINDUP_EN to enable conditional integration (integrator held while output pushes into a clamp).
module pid_seq_ctrl #(
  parameter int DW   = 8,
  parameter int GW   = 8,
  parameter int ACCW = 16,
  parameter int DIVW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [7:0]      cfg_wdata,
  input  logic [DIVW-1:0] rate_div,
  input  logic            sample_req,
  input  logic [DW-1:0]   setpoint,
  input  logic [DW-1:0]   feedback,
  output logic [DW-1:0]   control_signal,
  output logic            busy,
  output logic            done,
  output logic            sat_out,
  output logic            overrun,
  output logic [2:0]      dbg_state
);

  localparam int AW = ACCW + GW + DW + 3;
  localparam int EW = DW + 1;
  localparam logic signed [AW-1:0] IMAX = AW'(2**(ACCW-1) - 1);
  localparam logic signed [AW-1:0] IMIN = -IMAX - AW'(1);
  localparam logic signed [AW-1:0] OMAX = AW'(2**DW - 1);

  typedef enum logic [2:0] {S_IDLE, S_CAP, S_P, S_I, S_D, S_OUT} state_t;

  state_t r_state, w_state_nxt;

  logic [GW-1:0]          r_kp_sh, r_ki_sh, r_kd_sh, r_kp, r_ki, r_kd;
  logic                   r_en, r_clr_pend, r_ovr;
  logic [DIVW-1:0]        r_presc;
  logic signed [EW-1:0]   r_err, r_prev_err;
  logic signed [ACCW-1:0] r_integ;
  logic signed [AW-1:0]   r_acc;
  logic [DW-1:0]          r_ctrl;
  logic                   r_done, r_sat, r_last_hi, r_last_lo;

  logic                   w_tick, w_trig, w_accept_ok, w_skip, w_ctrl_wr;
  logic signed [AW-1:0]   w_err_x, w_derr_x, w_kp_x, w_ki_x, w_kd_x;
  logic signed [AW-1:0]   w_integ_ext, w_integ_base, w_integ_sum, w_integ_next_x;
  logic signed [ACCW-1:0] w_integ_sat, w_integ_next;

  // Trigger is a one-cycle request with no backpressure: it is accepted in IDLE or OUT, otherwise it is
  // dropped and flagged as overrun. done is a one-cycle valid qualifying control_signal and sat_out.
  assign w_tick      = r_en && (rate_div != '0) && (r_presc >= rate_div);
  assign w_trig      = (rate_div == '0) ? (r_en && sample_req) : w_tick;
  assign w_accept_ok = (r_state == S_IDLE) || (r_state == S_OUT);
  assign w_ctrl_wr   = cfg_we && (cfg_addr == 2'd3);

  assign w_err_x      = AW'(r_err);
  assign w_derr_x     = AW'(r_err) - AW'(r_prev_err);
  assign w_kp_x       = AW'($signed({1'b0, r_kp}));
  assign w_ki_x       = AW'($signed({1'b0, r_ki}));
  assign w_kd_x       = AW'($signed({1'b0, r_kd}));
  assign w_integ_ext  = AW'(r_integ);
  assign w_integ_base = r_clr_pend ? '0 : w_integ_ext;
  assign w_integ_sum  = w_integ_base + w_ki_x * w_err_x;
  assign w_integ_sat  = (w_integ_sum > IMAX) ? IMAX[ACCW-1:0] :
                        (w_integ_sum < IMIN) ? IMIN[ACCW-1:0] : w_integ_sum[ACCW-1:0];

`ifdef PID_ANTIWINDUP_EN
  assign w_skip = (r_last_hi && (r_err > 0)) || (r_last_lo && (r_err < 0));
`else
  assign w_skip = 1'b0;
`endif

  assign w_integ_next   = w_skip ? w_integ_base[ACCW-1:0] : w_integ_sat;
  assign w_integ_next_x = AW'(w_integ_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_trig) w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = S_P;
      S_P:     w_state_nxt = S_I;
      S_I:     w_state_nxt = S_D;
      S_D:     w_state_nxt = S_OUT;
      S_OUT:   w_state_nxt = w_trig ? S_CAP : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Configuration, prescaler and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kp_sh <= '0; r_ki_sh <= '0; r_kd_sh <= '0;
      r_en <= 1'b0; r_clr_pend <= 1'b0; r_ovr <= 1'b0; r_presc <= '0;
    end else begin
      if (cfg_we && cfg_addr == 2'd0) r_kp_sh <= GW'(cfg_wdata);
      if (cfg_we && cfg_addr == 2'd1) r_ki_sh <= GW'(cfg_wdata);
      if (cfg_we && cfg_addr == 2'd2) r_kd_sh <= GW'(cfg_wdata);
      if (w_ctrl_wr) r_en <= cfg_wdata[0];
      if (w_ctrl_wr && cfg_wdata[1]) r_clr_pend <= 1'b1;
      else if (r_state == S_I)       r_clr_pend <= 1'b0;
      if (w_trig && !w_accept_ok)    r_ovr <= 1'b1;
      else if (w_ctrl_wr && cfg_wdata[2]) r_ovr <= 1'b0;
      if (!r_en || rate_div == '0 || r_presc >= rate_div) r_presc <= '0;
      else r_presc <= r_presc + 1'b1;
    end
  end

  // Step datapath; gains are captured in CAP so a sample always uses one consistent set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kp <= '0; r_ki <= '0; r_kd <= '0;
      r_err <= '0; r_prev_err <= '0; r_integ <= '0; r_acc <= '0;
      r_ctrl <= '0; r_done <= 1'b0; r_sat <= 1'b0; r_last_hi <= 1'b0; r_last_lo <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_sat  <= 1'b0;
      case (r_state)
        S_CAP: begin
          r_kp  <= (cfg_we && cfg_addr == 2'd0) ? GW'(cfg_wdata) : r_kp_sh;
          r_ki  <= (cfg_we && cfg_addr == 2'd1) ? GW'(cfg_wdata) : r_ki_sh;
          r_kd  <= (cfg_we && cfg_addr == 2'd2) ? GW'(cfg_wdata) : r_kd_sh;
          r_err <= $signed({1'b0, setpoint}) - $signed({1'b0, feedback});
        end
        S_P: r_acc <= w_kp_x * w_err_x;
        S_I: begin
          r_integ <= w_integ_next;
          r_acc   <= r_acc + w_integ_next_x;
        end
        S_D: begin
          r_acc      <= r_acc + w_kd_x * w_derr_x;
          r_prev_err <= r_err;
        end
        S_OUT: begin
          r_done    <= 1'b1;
          r_last_hi <= (r_acc > OMAX);
          r_last_lo <= r_acc[AW-1];
          if (r_acc[AW-1]) begin
            r_ctrl <= '0;
            r_sat  <= 1'b1;
          end else if (r_acc > OMAX) begin
            r_ctrl <= '1;
            r_sat  <= 1'b1;
          end else begin
            r_ctrl <= r_acc[DW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign control_signal = r_ctrl;
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign sat_out        = r_sat;
  assign overrun        = r_ovr;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_pid_seq_ctrl.sv
// Self-checking bench for pid_seq_ctrl: directed literal cases plus randomized traffic against a
// sample-level behavioural model compared every cycle.
module tb_pid_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic [15:0] rate_div = '0;
  logic        sample_req = 1'b0;
  logic [7:0]  setpoint = '0;
  logic [7:0]  feedback = '0;
  wire  [7:0]  control_signal;
  wire         busy, done, sat_out, overrun;
  wire  [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  pid_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .rate_div(rate_div), .sample_req(sample_req), .setpoint(setpoint), .feedback(feedback),
    .control_signal(control_signal), .busy(busy), .done(done), .sat_out(sat_out),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: one computed result per accepted sample, phase counts cycles since trigger
  int   m_kp_sh = 0, m_ki_sh = 0, m_kd_sh = 0, m_kp = 0, m_ki = 0, m_kd = 0;
  bit   m_en = 0, m_pend = 0, m_ovr = 0, m_hi = 0, m_lo = 0;
  int   m_integ = 0, m_prev = 0, m_err = 0, m_cnt = 0, m_phase = 0;
  logic [7:0] exp_ctrl = '0;
  logic exp_done = 1'b0, exp_sat = 1'b0;
  logic [8:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    bit tick, trig, skip;
    int base, sum, acc;
    logic [8:0] e;
    if (!rst_n) begin
      m_kp_sh = 0; m_ki_sh = 0; m_kd_sh = 0; m_kp = 0; m_ki = 0; m_kd = 0;
      m_en = 0; m_pend = 0; m_ovr = 0; m_hi = 0; m_lo = 0;
      m_integ = 0; m_prev = 0; m_err = 0; m_cnt = 0; m_phase = 0;
      exp_ctrl = '0; exp_done = 0; exp_sat = 0;
      exp_q.delete();
    end else begin
      tick = 0;
      if (m_en && rate_div != 0) begin
        if (m_cnt == int'(rate_div)) begin tick = 1; m_cnt = 0; end
        else m_cnt++;
      end else m_cnt = 0;
      trig = m_en && ((rate_div == 0) ? sample_req : tick);
      exp_done = 0;
      exp_sat = 0;
      if (m_phase == 1) begin
        m_kp = (cfg_we && cfg_addr == 0) ? int'(cfg_wdata) : m_kp_sh;
        m_ki = (cfg_we && cfg_addr == 1) ? int'(cfg_wdata) : m_ki_sh;
        m_kd = (cfg_we && cfg_addr == 2) ? int'(cfg_wdata) : m_kd_sh;
        m_err = int'(setpoint) - int'(feedback);
      end
      if (m_phase == 3) begin
        base = m_pend ? 0 : m_integ;
        m_pend = 0;
        skip = 0;
`ifdef PID_ANTIWINDUP_EN
        skip = (m_hi && m_err > 0) || (m_lo && m_err < 0);
`endif
        sum = base;
        if (!skip) begin
          sum = base + m_ki * m_err;
          if (sum > 32767) sum = 32767;
          if (sum < -32768) sum = -32768;
        end
        m_integ = sum;
        acc = m_kp * m_err + m_integ + m_kd * (m_err - m_prev);
        m_prev = m_err;
        if (acc < 0) e = {1'b1, 8'd0};
        else if (acc > 255) e = {1'b1, 8'hff};
        else e = {1'b0, 8'(acc)};
        exp_q.push_back(e);
      end
      if (m_phase == 5 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_ctrl = e[7:0];
        exp_sat = e[8];
        exp_done = 1;
        m_hi = e[8] && (e[7:0] == 8'hff);
        m_lo = e[8] && (e[7:0] == 8'h00);
      end
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: m_kp_sh = int'(cfg_wdata);
          2'd1: m_ki_sh = int'(cfg_wdata);
          2'd2: m_kd_sh = int'(cfg_wdata);
          default: begin
            m_en = cfg_wdata[0];
            if (cfg_wdata[1]) m_pend = 1;
            if (cfg_wdata[2]) m_ovr = 0;
          end
        endcase
      end
      if (trig && m_phase >= 1 && m_phase <= 4) m_ovr = 1;
      if (m_phase == 0 || m_phase == 5) m_phase = trig ? 1 : 0;
      else m_phase++;
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    check("ctrl", 64'(control_signal), 64'(exp_ctrl));
    check("done", 64'(done), 64'(exp_done));
    check("sat", 64'(sat_out), 64'(exp_sat));
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("overrun", 64'(overrun), 64'(m_ovr));
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; cfg_we = 1'b0; sample_req = 1'b0; rate_div = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_sample(input int sp, input int fb, input int exp_c, input int exp_s, input string name);
    int lat;
    setpoint = 8'(sp); feedback = 8'(fb);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    wait_done(lat);
    check({name, "_lat"}, 64'(lat), 64'd5);
    check({name, "_ctrl"}, 64'(control_signal), 64'(exp_c));
    check({name, "_sat"}, 64'(sat_out), 64'(exp_s));
  endtask

  initial begin
    int lat;
    logic [7:0] w;
    #1;
    check("rst_ctrl", 64'(control_signal), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    apply_reset();

    // proportional, including clamping both ways
    cfg_write(2'd0, 8'd2);
    cfg_write(2'd3, 8'h01);
    do_sample(100, 60, 80, 0, "p_basic");
    tick();
    check("p_done_pulse", 64'(done), 64'd0);
    do_sample(10, 50, 0, 1, "p_clamp_lo");
    do_sample(255, 0, 255, 1, "p_clamp_hi");

    // integrator and clr_integ
    apply_reset();
    cfg_write(2'd1, 8'd1);
    cfg_write(2'd3, 8'h01);
    do_sample(60, 50, 10, 0, "i_1");
    do_sample(60, 50, 20, 0, "i_2");
    do_sample(60, 50, 30, 0, "i_3");
    cfg_write(2'd3, 8'h03);
    do_sample(60, 50, 10, 0, "i_clr");

    // derivative
    apply_reset();
    cfg_write(2'd2, 8'd1);
    cfg_write(2'd3, 8'h01);
    do_sample(20, 0, 20, 0, "d_1");
    do_sample(30, 0, 10, 0, "d_2");
    do_sample(20, 0, 0, 1, "d_neg");

    // prescaled sampling period
    apply_reset();
    cfg_write(2'd0, 8'd1);
    rate_div = 16'd9;
    cfg_write(2'd3, 8'h01);
    wait_done(lat);
    wait_done(lat);
    check("period", 64'(lat), 64'd10);

    // overrun is sticky until cleared
    cfg_write(2'd3, 8'h00);
    rate_div = '0;
    repeat (8) tick();
    cfg_write(2'd3, 8'h01);
    sample_req = 1'b1; tick(); sample_req = 1'b0; tick();
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    check("ovr_set", 64'(overrun), 64'd1);
    repeat (8) tick();
    cfg_write(2'd3, 8'h01);
    check("ovr_sticky", 64'(overrun), 64'd1);
    cfg_write(2'd3, 8'h05);
    check("ovr_clr", 64'(overrun), 64'd0);

    // gain writes mid-sample and at capture
    cfg_write(2'd0, 8'd2);
    setpoint = 8'd100; feedback = 8'd60;
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    tick();
    cfg_write(2'd0, 8'd3);
    wait_done(lat);
    check("kp_mid", 64'(control_signal), 64'd80);
    do_sample(100, 60, 120, 0, "kp_next");
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    cfg_write(2'd0, 8'd1);
    wait_done(lat);
    check("kp_cap", 64'(control_signal), 64'd40);

    // async reset during the P step
    cfg_write(2'd0, 8'd2);
    do_sample(100, 60, 80, 0, "pre_rst");
    setpoint = 8'd100; feedback = 8'd80;
    sample_req = 1'b1; tick(); sample_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", 64'(control_signal), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    cfg_write(2'd0, 8'd1);
    cfg_write(2'd2, 8'd1);
    cfg_write(2'd3, 8'h01);
    do_sample(30, 0, 60, 0, "post_rst");

    // windup behaviour
    apply_reset();
    cfg_write(2'd1, 8'd1);
    cfg_write(2'd3, 8'h01);
    do_sample(200, 0, 200, 0, "w_1");
    do_sample(200, 0, 255, 1, "w_2");
    do_sample(200, 0, 255, 1, "w_3");
`ifdef PID_ANTIWINDUP_EN
    do_sample(0, 255, 145, 0, "w_recover");
`else
    do_sample(0, 255, 255, 1, "w_recover");
`endif

    // randomized traffic
    apply_reset();
    cfg_write(2'd0, 8'($urandom_range(4, 0)));
    cfg_write(2'd1, 8'($urandom_range(3, 0)));
    cfg_write(2'd2, 8'($urandom_range(4, 0)));
    cfg_write(2'd3, 8'h01);
    for (int n = 0; n < 1600; n++) begin
      if (n == 800) begin
        cfg_write(2'd3, 8'h00);
        rate_div = 16'($urandom_range(12, 4));
      end
      cfg_we = 1'b0;
      if ($urandom_range(7, 0) == 0) begin
        cfg_we = 1'b1;
        cfg_addr = 2'($urandom_range(3, 0));
        w = 8'($urandom_range(255, 0));
        if (cfg_addr == 2'd3) begin
          w[0] = ($urandom_range(7, 0) != 0);
          w[1] = ($urandom_range(3, 0) == 0);
          w[2] = ($urandom_range(3, 0) == 0);
        end
        cfg_wdata = w;
      end
      sample_req = ($urandom_range(5, 0) == 0);
      setpoint = 8'($urandom_range(255, 0));
      feedback = 8'($urandom_range(255, 0));
      tick();
    end
    cfg_we = 1'b0;
    sample_req = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
